// File: rtl/riscv_mdu_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// datapath width, funct3 operation codes and the FSM state encoding.
package riscv_mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/riscv_mdu.sv
// RV32M multiply/divide, one result bit per cycle; latency 34 (1 for div-by-0/overflow).
// No backpressure: start is taken only in IDLE/DONE, busy stalls the pipe, kill aborts.
module riscv_mdu
    import riscv_mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t state, state_nxt;

    logic [4:0]        cnt;
    logic [2:0]        f3;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opr;
    logic [XLEN-1:0]   mb;
    logic              neg;
    logic              rneg;

    logic            accept, step, fix_en;
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    logic [XLEN:0]     add_a, add_b, sum;
    logic              sub;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    // Operand decode at accept time
    always_comb begin
        is_div   = funct3[2];
        a_sgn    = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
        b_sgn    = a_sgn && (funct3 != F3_MULHSU);
        a_neg    = a_sgn && op_a[XLEN-1];
        b_neg    = b_sgn && op_b[XLEN-1];
        mag_a    = a_neg ? -op_a : op_a;
        mag_b    = b_neg ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0] &&
                   (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special  = div_zero || div_ovf;
        if (funct3[1])
            special_res = div_zero ? op_a : '0;
        else
            special_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: begin
                if (kill)              state_nxt = IDLE;
                else if (cnt == 5'd31) state_nxt = FIX;
            end
            FIX:  state_nxt = kill ? IDLE : DONE;
            DONE: begin
                if (accept) state_nxt = special ? DONE : CALC;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: control outputs
    always_comb begin
        accept = start && ((state == IDLE) || (state == DONE));
        step   = (state == CALC) && !kill;
        fix_en = (state == FIX) && !kill;
    end

    // Shared 33-bit adder: shift-add for multiply, trial subtract for divide
    always_comb begin
        if (f3[2]) begin
            add_a = {acc[2*XLEN-1:XLEN], opr[XLEN-1]};
            add_b = {1'b0, mb};
            sub   = 1'b1;
        end else begin
            add_a = {1'b0, acc[2*XLEN-1:XLEN]};
            add_b = opr[0] ? {1'b0, mb} : '0;
            sub   = 1'b0;
        end
        sum = add_a + (add_b ^ {(XLEN+1){sub}}) + {{XLEN{1'b0}}, sub};
    end

    always_comb begin
        prod = neg  ? -acc : acc;
        quo  = neg  ? -opr : opr;
        rem  = rneg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (f3)
            F3_MUL:                       fix_res = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_res = quo;
            default:                      fix_res = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            f3   <= '0;
            acc  <= '0;
            opr  <= '0;
            mb   <= '0;
            neg  <= 1'b0;
            rneg <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            f3   <= funct3;
            acc  <= '0;
            neg  <= a_neg ^ b_neg;
            rneg <= a_neg;
            opr  <= is_div ? mag_a : mag_b;
            mb   <= is_div ? mag_b : mag_a;
        end else if (step) begin
            cnt <= cnt + 5'd1;
            if (f3[2]) begin
                // A borrow out of the trial subtraction restores the shifted remainder
                acc[2*XLEN-1:XLEN] <= sum[XLEN] ? add_a[XLEN-1:0] : sum[XLEN-1:0];
                opr                <= {opr[XLEN-2:0], ~sum[XLEN]};
            end else begin
                acc <= {sum, acc[XLEN-1:1]};
                opr <= {1'b0, opr[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (accept && special) result <= special_res;
            else if (fix_en)       result <= fix_res;
            busy <= (state_nxt == CALC) || (state_nxt == FIX);
            done <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_riscv_mdu.sv
// Directed bench for riscv_mdu: drives and samples on the falling edge,
// checks results, latency, busy span, kill, reset and back-to-back starts.
module tb_riscv_mdu;
    import riscv_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    int busy_cycles;

    riscv_mdu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge: that cycle becomes the start cycle.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
    endtask

    // Keeps start high (with junk operands) for cycles 1..hold-1, then waits for done.
    task automatic wait_done(input string tag, input logic [31:0] exp_res,
                             input int exp_lat, input int hold);
        int lat = 0;
        busy_cycles = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat < hold) begin
                start  = 1'b1;
                funct3 = F3_MUL;
                op_a   = 32'h0000_1234;
                op_b   = 32'h0000_5678;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cycles++;
        end while (!done && lat < 60);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp_res);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        kill   = 1'b0;
        funct3 = 3'b000;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start_op(F3_MUL, 32'd7, 32'hFFFF_FFFD);
        wait_done("MUL 7*-3", 32'hFFFF_FFEB, 34, 1);
        check("MUL busy cycles", 32'(busy_cycles), 32'd33);
        @(negedge clk);
        check("done single pulse", {31'b0, done}, 32'd0);
        check("idle busy", {31'b0, busy}, 32'd0);

        start_op(F3_MULH, 32'h8000_0000, 32'h8000_0000);
        wait_done("MULH min*min", 32'h4000_0000, 34, 1);
        start_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("MULHU max*max", 32'hFFFF_FFFE, 34, 1);
        start_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("MULHSU -1*max", 32'hFFFF_FFFF, 34, 1);
        start_op(F3_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("DIV -7/2", 32'hFFFF_FFFD, 34, 1);
        start_op(F3_REM, 32'hFFFF_FFF9, 32'd2);
        wait_done("REM -7/2", 32'hFFFF_FFFF, 34, 1);
        start_op(F3_DIVU, 32'd100, 32'd7);
        wait_done("DIVU 100/7", 32'd14, 34, 1);
        start_op(F3_REMU, 32'd100, 32'd7);
        wait_done("REMU 100/7", 32'd2, 34, 1);

        start_op(F3_DIVU, 32'd5, 32'd0);
        wait_done("DIVU 5/0", 32'hFFFF_FFFF, 1, 1);
        start_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("DIV overflow", 32'h8000_0000, 1, 1);
        start_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("REM overflow", 32'd0, 1, 1);
        start_op(F3_REMU, 32'd5, 32'd0);
        wait_done("REMU 5/0", 32'd5, 1, 1);

        // Kill 10 cycles into a divide, with a competing start in the same cycle
        start_op(F3_DIV, 32'd100, 32'd7);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        kill  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        kill  = 1'b0;
        start = 1'b0;
        check("kill busy", {31'b0, busy}, 32'd0);
        check("kill done", {31'b0, done}, 32'd0);
        check("kill result kept", result, 32'd5);
        repeat (3) @(negedge clk);
        check("kill stays idle", {30'b0, busy, done}, 32'd0);

        start_op(F3_MUL, 32'd3, 32'd4);
        wait_done("MUL 3*4 after kill", 32'd12, 34, 1);

        // Start held high through most of CALC must not restart the divide
        start_op(F3_DIVU, 32'd100, 32'd7);
        wait_done("start held in CALC", 32'd14, 34, 20);

        // Back-to-back: new start presented in the DONE cycle
        start_op(F3_MUL, 32'd3, 32'd5);
        wait_done("b2b first", 32'd15, 34, 1);
        start_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("b2b second", 32'hFFFF_FFFE, 34, 1);

        // Asynchronous reset in the middle of CALC
        start_op(F3_MUL, 32'd3, 32'd5);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre-reset busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", {31'b0, busy}, 32'd0);
        check("mid reset done", {31'b0, done}, 32'd0);
        check("mid reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(F3_DIV, 32'hFFFF_FF9C, 32'd7);
        wait_done("DIV -100/7 after reset", 32'hFFFF_FFF2, 34, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_mdu.md
# riscv_mdu

Iterative multiply/divide unit implementing the RV32M operations for the core's execute stage. It sits beside the ALU, downstream of the operand-B select stage, and consumes `op_a` (rs1) and `op_b` (rs2, always register source for M-type). One operation runs at a time behind a start/busy/done handshake, with one result bit processed per cycle. The control unit stalls the pipeline while `busy` is high.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk` input 1, single clock; all state updates on the rising edge.
- `rst_n` input 1, asynchronous active-low reset.
- `start` input 1, request a new operation; sampled only when the unit can accept.
- `kill` input 1, synchronous abort of the in-flight operation (pipeline flush).
- `funct3` input 3, operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` input XLEN, rs1 value; multiplicand or dividend.
- `op_b` input XLEN, rs2 value; multiplier or divisor.
- `busy` output 1, high while an operation is in flight.
- `done` output 1, single-cycle pulse when `result` becomes valid.
- `result` output XLEN, final value; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **Accept.** `start` is accepted in IDLE or DONE.
  - On accept, the unit latches `funct3`, the operand magnitudes and the result sign, and sets the step counter to 0.
  - `start` is ignored in CALC and FIX.
- **Multiply.** Unsigned shift-add on the magnitudes over 32 CALC cycles into a 64-bit product.
  - Signedness per operand: MUL/MULH treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned.
  - FIX negates the 64-bit product if the sign is negative.
  - MUL returns the low 32 bits; MULH, MULHSU and MULHU return the high 32 bits.
- **Divide.** Restoring division on the magnitudes over 32 CALC cycles.
  - FIX applies the signs: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- **Special cases.** Detected at accept; they skip CALC and FIX and go directly to DONE.
  - Divisor = 0: quotient 0xFFFFFFFF; remainder = `op_a`.
  - Signed overflow (DIV/REM, `op_a` = 0x80000000 and `op_b` = 0xFFFFFFFF): quotient 0x80000000; remainder 0.
- **Kill.** `kill` in CALC or FIX returns the unit to IDLE at the next edge.
  - No `done` is produced and `result` is unchanged.
  - If `kill` and `start` are high together, `kill` wins and the start is dropped.
- **Reset.** `rst_n` low, at any time: state IDLE, `busy` = 0, `done` = 0, `result` = 0, counter = 0.

## Timing
- Cycle numbering: the edge that accepts `start` is E0.
- Normal path:
  - E0 → CALC (counter 0).
  - E1..E32 → one iteration per edge; at E32 (counter = 31) → FIX.
  - E33 → DONE.
- `done` = 1 and `result` is valid in the cycle after E33: latency 34 cycles from the start cycle.
- Special-case path: E0 → DONE; `done` is high in the cycle after E0 (latency 1).
- `busy`:
  - It is registered.
  - It is high from the cycle after an accepting edge up to, but not including, the DONE cycle.
  - It is low in IDLE and DONE.
- DONE lasts one cycle, then the unit returns to IDLE unless `start` is high in that cycle. A start in DONE is accepted back-to-back, with no bubble.
- `result` changes only on entry to DONE.

## Structure
- Package `riscv_mdu_pkg` holds:
  - the `funct3` localparams (MUL … REMU);
  - the state encoding (2-bit enum IDLE/CALC/FIX/DONE);
  - `XLEN`.
- Single module with no sub-module.
  - The datapath is one shared 64-bit accumulator/remainder register plus a 32-bit operand shift register.
  - It uses one 33-bit adder/subtractor, reused by both the multiply and divide paths.

## Test plan
- MUL `op_a` = 7, `op_b` = 0xFFFFFFFD → `result` 0xFFFFFFEB; `done` pulses exactly 34 cycles after the start cycle; `busy` is high for 33 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, `done` one cycle after start; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, same latency.
- `kill` asserted 10 cycles into a DIV → `busy` low next cycle, no `done`, `result` keeps its prior value. A subsequent MUL 3×4 → 12.
- `rst_n` low mid-CALC → `busy`, `done` and `result` go to 0 immediately. A `start` held during CALC is ignored. A `start` in the DONE cycle is accepted: second `done` 34 cycles later.
